viterbi_traceback_unit: RTL and testbench

Parametrised traceback survivor-path memory for the Viterbi decoder. Sits after the add-compare-select stage. Each accepted trellis step stores one survivor decision bit per state in a circular buffer of TB_DEPTH entries. Once the buffer is full, every new step starts at the minimum-metric state, traces back TB_DEPTH-1 steps and emits one decoded bit. This replaces the fixed 4-state, depth-1 decision tracker with configurable state count, metric width and traceback depth, plus a ready/valid input handshake.

---
 rtl/viterbi_traceback_unit.sv | 156 +++++++++++++++
 tb/tb_viterbi_traceback_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_traceback_unit.sv
// Traceback survivor-path memory for a Viterbi decoder: stores one decision
// word per trellis step and, once full, traces back from the best state to emit one bit.
module viterbi_traceback_unit #(
    parameter int STATE_BITS = 2,
    parameter int TB_DEPTH   = 8,
    parameter int PM_W       = 4
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_valid,
    output logic                                o_ready,
    input  logic [(1<<STATE_BITS)-1:0]          i_decision,
    input  logic [(1<<STATE_BITS)*PM_W-1:0]     i_pm,
    output logic                                o_bit,
    output logic                                o_valid
);

    localparam int NS    = 1 << STATE_BITS;
    localparam int PTR_W = $clog2(TB_DEPTH);
    localparam int CNT_W = $clog2(TB_DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(TB_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(TB_DEPTH);
    localparam logic [CNT_W-1:0] STEP_INIT = CNT_W'(TB_DEPTH - 1);
    localparam logic [CNT_W-1:0] STEP_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_TRACE  = 2'd1,
        ST_EMIT   = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [CNT_W-1:0]        step_q, step_d;
    logic [STATE_BITS-1:0]   tb_state_q, tb_state_d;
    logic                    bit_q, bit_d;
    logic                    valid_q, valid_d;

    logic [NS-1:0]           mem_q [TB_DEPTH];

    logic [STATE_BITS-1:0]   best_idx_s;
    logic [PM_W-1:0]         best_pm_s;
    logic                    xfer_s;
    logic                    ready_s;
    logic [CNT_W-1:0]        count_inc_s;
    logic                    trace_bit_s;
    logic [STATE_BITS-1:0]   tb_next_s;

    // Argmin over path metrics; strict less-than keeps the lowest index on ties.
    always_comb begin
        best_idx_s = '0;
        best_pm_s  = i_pm[0 +: PM_W];
        for (int s = 1; s < NS; s++) begin
            best_idx_s = (i_pm[s*PM_W +: PM_W] < best_pm_s) ? STATE_BITS'(s) : best_idx_s;
            best_pm_s  = (i_pm[s*PM_W +: PM_W] < best_pm_s) ? i_pm[s*PM_W +: PM_W] : best_pm_s;
        end
    end

    // One traceback hop: predecessor = {state[M-2:0], decision of state}.
    always_comb begin
        trace_bit_s = mem_q[rd_ptr_q][tb_state_q];
        tb_next_s   = {tb_state_q[STATE_BITS-2:0], trace_bit_s};
        count_inc_s = (count_q == CNT_FULL) ? count_q : count_q + CNT_W'(1);
    end

    // FSM next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        step_d     = step_q;
        tb_state_d = tb_state_q;
        bit_d      = bit_q;
        valid_d    = 1'b0;
        ready_s    = 1'b0;
        xfer_s     = 1'b0;
        case (state_q)
            ST_ACCEPT: begin
                ready_s = 1'b1;
                if (i_valid) begin
                    xfer_s     = 1'b1;
                    rd_ptr_d   = wr_ptr_q;
                    wr_ptr_d   = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
                    count_d    = count_inc_s;
                    tb_state_d = best_idx_s;
                    if (count_inc_s == CNT_FULL) begin
                        state_d = ST_TRACE;
                        step_d  = STEP_INIT;
                    end else begin
                        state_d = ST_ACCEPT;
                    end
                end else begin
                    state_d = ST_ACCEPT;
                end
            end
            ST_TRACE: begin
                tb_state_d = tb_next_s;
                rd_ptr_d   = (rd_ptr_q == '0) ? LAST_PTR : rd_ptr_q - PTR_W'(1);
                step_d     = step_q - CNT_W'(1);
                if (step_q == STEP_ONE) begin
                    bit_d   = tb_next_s[STATE_BITS-1];
                    valid_d = 1'b1;
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_TRACE;
                end
            end
            ST_EMIT: begin
                valid_d = 1'b0;
                state_d = ST_ACCEPT;
            end
            default: begin
                state_d = ST_ACCEPT;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_ACCEPT;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            step_q     <= '0;
            tb_state_q <= '0;
            bit_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            step_q     <= step_d;
            tb_state_q <= tb_state_d;
            bit_q      <= bit_d;
            valid_q    <= valid_d;
        end
    end

    // Survivor memory is data-only, so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (xfer_s) begin
            mem_q[wr_ptr_q] <= i_decision;
        end
    end

    assign o_ready = ready_s;
    assign o_bit   = bit_q;
    assign o_valid = valid_q;

endmodule

// File: tb/tb_viterbi_traceback_unit.sv
// Self-checking bench for viterbi_traceback_unit (M=2, D=4, PM_W=4) against a
// queue-based software traceback model.
module tb_viterbi_traceback_unit;

    localparam int M  = 2;
    localparam int D  = 4;
    localparam int PW = 4;
    localparam int NS = 4;

    logic              clk     = 1'b0;
    logic              rst     = 1'b1;
    logic              i_valid = 1'b0;
    logic [NS-1:0]     dec     = '0;
    logic [NS*PW-1:0]  pm      = '0;
    logic              o_ready;
    logic              o_bit;
    logic              o_valid;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ts     = 0;

    logic [NS-1:0]     h_dec[$];
    logic [NS*PW-1:0]  h_pm[$];
    int                h_u[$];
    int                exp_bit[$];
    int                exp_cyc[$];
    int                exp_u[$];
    logic              obs_bit[$];
    int                obs_cyc[$];

    viterbi_traceback_unit #(.STATE_BITS(M), .TB_DEPTH(D), .PM_W(PW)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_decision (dec),
        .i_pm       (pm),
        .o_bit      (o_bit),
        .o_valid    (o_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            obs_bit.push_back(o_bit);
            obs_cyc.push_back(cyc);
        end
    end

    function automatic int pm_of(input logic [NS*PW-1:0] v, input int s);
        return int'(v[s*PW +: PW]);
    endfunction

    function automatic int best_state(input logic [NS*PW-1:0] v);
        int b = 0;
        for (int s = 1; s < NS; s++) if (pm_of(v, s) < pm_of(v, b)) b = s;
        return b;
    endfunction

    // State reached after n backward hops from the best state of the newest step.
    function automatic int model_state(input int n);
        int s;
        logic [NS-1:0] dv;
        s = best_state(h_pm[D-1]);
        for (int k = 0; k < n; k++) begin
            dv = h_dec[D-1-k];
            s = ((s << 1) | int'(dv[s])) % NS;
        end
        return s;
    endfunction

    function automatic void model_push(input logic [NS-1:0] d, input logic [NS*PW-1:0] p, input int u);
        h_dec.push_back(d);
        h_pm.push_back(p);
        h_u.push_back(u);
        if (h_dec.size() > D) begin
            void'(h_dec.pop_front());
            void'(h_pm.pop_front());
            void'(h_u.pop_front());
        end
        if (h_dec.size() == D) begin
            exp_bit.push_back((model_state(D-1) >> (M-1)) & 1);
            exp_cyc.push_back(cyc + D);
            exp_u.push_back(h_u[0]);
        end
    endfunction

    // Random step consistent with a K=3 encoder path; the true state gets metric 0.
    task automatic gen_step(output logic [NS-1:0] d, output logic [NS*PW-1:0] p, output int u);
        int nxt;
        u   = int'($urandom_range(0, 1));
        nxt = (u << 1) | (ts >> 1);
        d   = NS'($urandom);
        d[nxt] = ts[0];
        for (int s = 0; s < NS; s++)
            p[s*PW +: PW] = (s == nxt) ? 4'd0 : PW'($urandom_range(1, 15));
        ts = nxt;
    endtask

    task automatic send(input logic [NS-1:0] d, input logic [NS*PW-1:0] p, input int u);
        int w = 0;
        i_valid = 1'b1;
        dec = d;
        pm  = p;
        while (o_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout o_ready=%b required=1", o_ready);
        end else begin
            model_push(d, p, u);
        end
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [NS-1:0] d;
        logic [NS*PW-1:0] p;
        int u;
        gen_step(d, p, u);
        send(d, p, u);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_bit !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_values valid=%b bit=%b ready=%b required 0 0 1", o_valid, o_bit, o_ready);
        end
        h_dec.delete();
        h_pm.delete();
        h_u.delete();
        exp_bit.delete();
        exp_cyc.delete();
        exp_u.delete();
        ts = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_outputs(input string name);
        repeat (D + 3) @(negedge clk);
        checks++;
        if (obs_bit.size() != exp_bit.size()) begin
            errors++;
            $display("FAIL %s_pulse_count got=%0d required=%0d", name, obs_bit.size(), exp_bit.size());
        end else begin
            for (int i = 0; i < exp_bit.size(); i++) begin
                checks++;
                if (obs_bit[i] !== exp_bit[i][0]) begin
                    errors++;
                    $display("FAIL %s_bit[%0d] got=%b required=%0d", name, i, obs_bit[i], exp_bit[i]);
                end
                checks++;
                if (obs_cyc[i] != exp_cyc[i]) begin
                    errors++;
                    $display("FAIL %s_cycle[%0d] got=%0d required=%0d", name, i, obs_cyc[i], exp_cyc[i]);
                end
                if (exp_u[i] >= 0) begin
                    checks++;
                    if (int'(obs_bit[i]) != exp_u[i]) begin
                        errors++;
                        $display("FAIL %s_source_bit[%0d] got=%b required=%0d", name, i, obs_bit[i], exp_u[i]);
                    end
                end
            end
        end
        exp_bit.delete();
        exp_cyc.delete();
        exp_u.delete();
        obs_bit.delete();
        obs_cyc.delete();
    endtask

    // Sends the buffer-filling step and follows tb_state through the whole trace.
    task automatic send_and_follow(input string name, input logic [NS-1:0] d, input logic [NS*PW-1:0] p);
        send(d, p, -1);
        for (int k = 0; k < D; k++) begin
            checks++;
            if (int'(dut.tb_state_q) != model_state(k)) begin
                errors++;
                $display("FAIL %s_tb_state[%0d] got=%0d required=%0d", name, k, dut.tb_state_q, model_state(k));
            end
            if (k < D - 1) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) send_rand();
        check_outputs("reset_partial_fill");
    endtask

    task automatic test_all_zero();
        do_reset();
        repeat (4) send(4'b0000, {4'd15, 4'd15, 4'd15, 4'd0}, -1);
        check_outputs("all_zero");
    endtask

    task automatic test_all_one();
        do_reset();
        repeat (3) send(4'b1111, {4'd0, 4'd9, 4'd9, 4'd9}, -1);
        send_and_follow("all_one", 4'b1111, {4'd0, 4'd9, 4'd9, 4'd9});
        check_outputs("all_one");
    endtask

    task automatic test_tie_break();
        do_reset();
        repeat (3) send(4'b0101, {4'd5, 4'd5, 4'd5, 4'd5}, -1);
        send_and_follow("tie", 4'b0101, {4'd5, 4'd5, 4'd5, 4'd5});
        check_outputs("tie");
    endtask

    task automatic test_handshake_wrap();
        logic [NS-1:0] d;
        logic [NS*PW-1:0] p;
        int u;
        int n = 0;
        int n_exp = 0;
        int want;
        bit accepted = 1'b1;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            checks++;
            if (int'(dut.wr_ptr_q) != n % D) begin
                errors++;
                $display("FAIL hs_wr_ptr c=%0d got=%0d required=%0d", c, dut.wr_ptr_q, n % D);
            end
            if (accepted) begin
                gen_step(d, p, u);
                i_valid = 1'b1;
                dec = d;
                pm  = p;
            end
            accepted = (o_ready === 1'b1);
            if (accepted) begin
                want = (n < D) ? n : (D - 1) + (n - D + 1) * (D + 1);
                checks++;
                if (c != want) begin
                    errors++;
                    $display("FAIL hs_transfer_cycle[%0d] got=%0d required=%0d", n, c, want);
                end
                model_push(d, p, u);
                n++;
            end
            @(negedge clk);
        end
        i_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            want = (k < D) ? k : (D - 1) + (k - D + 1) * (D + 1);
            if (want < 30) n_exp++;
        end
        checks++;
        if (n != n_exp) begin
            errors++;
            $display("FAIL hs_transfer_total got=%0d required=%0d", n, n_exp);
        end
        check_outputs("handshake");
    endtask

    task automatic test_reset_mid_trace();
        do_reset();
        repeat (4) send_rand();
        @(negedge clk);
        do_reset();
        repeat (3) send_rand();
        check_outputs("mid_trace_after3");
        send_rand();
        check_outputs("mid_trace_after4");
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_all_zero();
        test_all_one();
        test_tie_break();
        test_handshake_wrap();
        test_reset_mid_trace();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
